logic_unit_arbiter: RTL and testbench

//  Shares one W-bit bitwise logic unit (AND/OR/XOR/NOR, built on the OR32/AND32 cells)

---
 rtl/logic_unit_arbiter.sv | 108 ++++++++++
 tb/tb_logic_unit_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between the DLX EX stage
// (port 0) and the TinyML engine (port 1); one op in flight, result held until taken.
module logic_unit_arbiter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [1:0]   req_op0,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_b0,
    input  logic [1:0]   req_op1,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b1,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         busy
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           prio;
    logic           owner;
    logic           grant;
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   alu;

    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        grant     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    // Contention goes to prio; otherwise the lone requester wins.
                    grant            = (&req_valid) ? prio : req_valid[1];
                    req_ready[grant] = 1'b1;
                    state_nxt        = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu = '0;
        unique case (op)
            OP_AND:  alu = a & b;
            OP_OR:   alu = a | b;
            OP_XOR:  alu = a ^ b;
            OP_NOR:  alu = ~(a | b);
            default: alu = '0;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            prio       <= 1'b0;
            owner      <= 1'b0;
            op         <= 2'b00;
            a          <= '0;
            b          <= '0;
            rsp_result <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid != 2'b00) begin
                owner <= grant;
                op    <= grant ? req_op1 : req_op0;
                a     <= grant ? req_a1  : req_a0;
                b     <= grant ? req_b1  : req_b0;
            end
            if (state == EXEC) begin
                rsp_result <= alu;
            end
            // Priority only moves when a response completes.
            if (state == RESP && rsp_ready[owner]) begin
                prio <= ~owner;
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: directed ops push expected results,
// an independent monitor pops and compares on every response handshake.
module tb_logic_unit_arbiter;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [1:0]   req_op0;
    logic [W-1:0] req_a0;
    logic [W-1:0] req_b0;
    logic [1:0]   req_op1;
    logic [W-1:0] req_a1;
    logic [W-1:0] req_b1;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [W-1:0] rsp_result;
    logic         busy;

    typedef struct {
        logic [1:0]   vec;
        logic [W-1:0] res;
        string        name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic_unit_arbiter #(.W(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_op1    (req_op1),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response handshake must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (!RST && (rsp_valid & rsp_ready) != 2'b00) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got valid %b result %h expected none",
                         rsp_valid, rsp_result);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_owner"}, {30'd0, rsp_valid}, {30'd0, e.vec});
                check({e.name, "_result"}, rsp_result, e.res);
            end
        end
    end

    task automatic drive(input int port, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        if (port == 0) begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end
    endtask

    task automatic wait_grant(input string name, output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (req_ready != 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no grant expected grant", name);
        end
    endtask

    // Issue one op and check grant, T+1 silence and T+2 response timing.
    task automatic run_op(input int port, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input string name,
                          input bit scramble);
        exp_t e;
        bit   got;
        logic [1:0] vec;
        vec    = (port == 0) ? 2'b01 : 2'b10;
        e.vec  = vec;
        e.res  = exp;
        e.name = name;
        q.push_back(e);
        @(posedge CLK); #1;
        drive(port, op, a, b);
        req_valid[port] = 1'b1;
        wait_grant(name, got);
        check({name, "_grant"}, {30'd0, req_ready}, {30'd0, vec});
        @(posedge CLK); #1;
        req_valid[port] = 1'b0;
        if (scramble) begin
            drive(port, 2'b00, '0, '0);
        end
        @(negedge CLK);
        check({name, "_t1"}, {30'd0, rsp_valid}, 32'd0);
        @(negedge CLK);
        check({name, "_t2"}, {30'd0, rsp_valid}, {30'd0, vec});
        @(posedge CLK);
    endtask

    initial begin
        bit got;
        logic [1:0] order [4];
        int cyc [4];
        int n;
        int cc;

        RST       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        drive(0, 2'b00, '0, '0);
        drive(1, 2'b00, '0, '0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_result", rsp_result, 32'd0);

        // Reset while a response is pending: it must vanish.
        rsp_ready = 2'b00;
        @(posedge CLK); #1;
        drive(0, 2'b01, 32'hFFFF_FFFF, 32'h0);
        req_valid = 2'b01;
        wait_grant("rst_op", got);
        @(posedge CLK); #1 req_valid = 2'b00;
        repeat (2) @(negedge CLK);
        check("rst_pending", {30'd0, rsp_valid}, 32'd1);
        @(posedge CLK); #1 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        rsp_ready = 2'b11;
        @(negedge CLK);
        check("rst_all_out", {rsp_result[27:0], busy, req_ready, rsp_valid[0]},
              32'd0);
        check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        repeat (4) @(negedge CLK);
        check("rst_no_rsp", {31'd0, busy}, 32'd0);

        run_op(0, 2'b01, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, "or0", 0);

        run_op(0, 2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, "and", 0);
        run_op(1, 2'b01, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hFFFF_0F0F, "or", 0);
        run_op(0, 2'b10, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, "xor", 0);
        run_op(1, 2'b11, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0000_F0F0, "nor", 0);

        // Contention: both held valid, grants must alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.vec  = (i % 2 == 0) ? 2'b01 : 2'b10;
            e.res  = (i % 2 == 0) ? 32'hEDCB_5678 : 32'h0A0A_0505;
            e.name = (i % 2 == 0) ? "rr0" : "rr1";
            q.push_back(e);
        end
        @(posedge CLK); #1;
        drive(0, 2'b10, 32'h1234_5678, 32'hFFFF_0000);
        drive(1, 2'b00, 32'hAAAA_5555, 32'h0F0F_0F0F);
        req_valid = 2'b11;
        n  = 0;
        cc = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge CLK);
            cc++;
            if (req_ready != 2'b00) begin
                order[n] = req_ready;
                cyc[n]   = cc;
                n++;
            end
        end
        @(posedge CLK); #1 req_valid = 2'b00;
        check("rr_count", n, 4);
        for (int i = 0; i < n; i++) begin
            check($sformatf("rr_order%0d", i), {30'd0, order[i]},
                  (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) check($sformatf("rr_gap%0d", i), cyc[i] - cyc[i-1], 3);
        end
        for (int i = 0; i < 20 && busy; i++) @(negedge CLK);
        check("rr_drain", {31'd0, busy}, 32'd0);

        // Back-pressure on owner 0; non-owner ready and a waiting requester 1.
        rsp_ready = 2'b10;
        begin
            exp_t e;
            e.vec = 2'b01; e.res = 32'hFF00_00FF; e.name = "bp0";
            q.push_back(e);
            e.vec = 2'b10; e.res = 32'hFFFF_FFFF; e.name = "bp1";
            q.push_back(e);
        end
        @(posedge CLK); #1;
        drive(0, 2'b01, 32'h0000_00FF, 32'hFF00_0000);
        drive(1, 2'b11, 32'h0, 32'h0);
        req_valid = 2'b01;
        wait_grant("bp0", got);
        check("bp0_grant", {30'd0, req_ready}, 32'd1);
        @(posedge CLK); #1 req_valid = 2'b10;
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold%0d", i),
                  {rsp_valid, busy, req_ready, 27'd0},
                  {2'b01, 1'b1, 2'b00, 27'd0});
            check($sformatf("bp_res%0d", i), rsp_result, 32'hFF00_00FF);
            @(negedge CLK);
        end
        rsp_ready = 2'b11;
        wait_grant("bp1", got);
        check("bp1_grant", {30'd0, req_ready}, 32'd2);
        @(posedge CLK); #1 req_valid = 2'b00;
        for (int i = 0; i < 20 && busy; i++) @(negedge CLK);

        run_op(1, 2'b10, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h2152_4110, "latch", 1);

        repeat (4) @(negedge CLK);
        check("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
